// File: rtl/pong_pkg.sv
// Pong shared definitions: screen/geometry constants, game state enum,
// coordinate types and pre-sized constants for the 11-bit position arithmetic.
package pong_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int BALL_SIZE    = 10;
    localparam int PADDLE_W     = 10;
    localparam int PADDLE_H     = 60;
    localparam int PADDLEL_X    = 3;
    localparam int PADDLER_X    = 630;
    localparam int BALL_SPEED   = 2;
    localparam int PADDLE_SPEED = 4;
    localparam int SERVE_FRAMES = 60;
    localparam int WIN_SCORE    = 9;

    localparam int COORD_W      = 10;
    localparam int SUM_W        = 11;
    localparam int SCORE_W      = 4;
    localparam int SERVE_CNT_W  = $clog2(SERVE_FRAMES);

    typedef logic [COORD_W-1:0]     coord_t;
    typedef logic [SUM_W-1:0]       sum_t;
    typedef logic [SCORE_W-1:0]     score_t;
    typedef logic [SERVE_CNT_W-1:0] serve_cnt_t;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    // Widened operands so that edge tests never wrap.
    localparam sum_t K_SCREEN_W     = sum_t'(SCREEN_W);
    localparam sum_t K_SCREEN_H     = sum_t'(SCREEN_H);
    localparam sum_t K_BALL_SIZE    = sum_t'(BALL_SIZE);
    localparam sum_t K_BALL_SPEED   = sum_t'(BALL_SPEED);
    localparam sum_t K_PADDLE_H     = sum_t'(PADDLE_H);
    localparam sum_t K_PADDLER_X    = sum_t'(PADDLER_X);
    localparam sum_t K_LHIT_X       = sum_t'(PADDLEL_X + PADDLE_W);
    localparam sum_t K_PADDLE_SPEED = sum_t'(PADDLE_SPEED);
    localparam sum_t K_PADDLE_MAX   = sum_t'(SCREEN_H - PADDLE_H);
    localparam sum_t K_BALL_HALF    = sum_t'(BALL_SIZE / 2);
    localparam sum_t K_PADDLE_HALF  = sum_t'(PADDLE_H / 2);
    localparam sum_t K_AUTO_DEAD    = sum_t'(2);

    // Stored-width coordinates.
    localparam coord_t C_BALL_SPEED   = coord_t'(BALL_SPEED);
    localparam coord_t C_PADDLE_SPEED = coord_t'(PADDLE_SPEED);
    localparam coord_t C_BALL_X0      = coord_t'((SCREEN_W - BALL_SIZE) / 2);
    localparam coord_t C_BALL_Y0      = coord_t'((SCREEN_H - BALL_SIZE) / 2);
    localparam coord_t C_PADDLE_Y0    = coord_t'((SCREEN_H - PADDLE_H) / 2);
    localparam coord_t C_BALL_Y_MAX   = coord_t'(SCREEN_H - BALL_SIZE);
    localparam coord_t C_RHIT_X       = coord_t'(PADDLER_X - BALL_SIZE);
    localparam coord_t C_LHIT_X       = coord_t'(PADDLEL_X + PADDLE_W);
    localparam coord_t C_PADDLE_MAX   = coord_t'(SCREEN_H - PADDLE_H);

    localparam score_t     C_SCORE_ONE  = score_t'(1);
    localparam score_t     C_WIN        = score_t'(WIN_SCORE);
    localparam serve_cnt_t C_SERVE_ONE  = serve_cnt_t'(1);
    localparam serve_cnt_t C_SERVE_LAST = serve_cnt_t'(SERVE_FRAMES - 1);

    // Zero-extend a stored coordinate into the sum width.
    function automatic sum_t widen(input coord_t v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle: clamped vertical step of PADDLE_SPEED per enabled frame.
// Both or neither request holds the paddle.
module pong_paddle_ctrl
    import pong_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   en_i,
    input  logic   up_i,
    input  logic   dn_i,
    output coord_t y_o
);

    coord_t y_q;
    coord_t y_d;
    sum_t   y_sum;

    // Next position: clamp at the top edge and at SCREEN_H-PADDLE_H.
    always_comb begin
        y_d   = y_q;
        y_sum = widen(y_q) + K_PADDLE_SPEED;
        if (up_i && !dn_i) begin
            y_d = (y_q < C_PADDLE_SPEED) ? '0 : y_q - C_PADDLE_SPEED;
        end else if (dn_i && !up_i) begin
            y_d = (y_sum > K_PADDLE_MAX) ? C_PADDLE_MAX : y_sum[COORD_W-1:0];
        end
    end

    // Position register, advanced only on enabled frames.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            y_q <= C_PADDLE_Y0;
        end else if (en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/pong_game_state.sv
// Pong frame-rate game engine: ball motion, paddle/wall collisions, scoring
// and SERVE/PLAY/GAME_OVER sequencing, advanced once per frame_tick.
// Optional feature: define PONG_AUTOPLAY_EN to let the right paddle chase
// the ball instead of following btn_r_up/btn_r_dn.
module pong_game_state
    import pong_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 frame_tick_i,
    input  logic                 btn_l_up_i,
    input  logic                 btn_l_dn_i,
    input  logic                 btn_r_up_i,
    input  logic                 btn_r_dn_i,
    input  logic                 start_i,
    output logic [COORD_W-1:0]   ball_x_o,
    output logic [COORD_W-1:0]   ball_y_o,
    output logic [COORD_W-1:0]   paddleL_y_o,
    output logic [COORD_W-1:0]   paddleR_y_o,
    output logic [SCORE_W-1:0]   score_l_o,
    output logic [SCORE_W-1:0]   score_r_o,
    output logic                 point_pulse_o,
    output logic                 game_over_o
);

    game_state_t state_q;
    serve_cnt_t  serve_cnt_q;
    coord_t      ball_x_q;
    coord_t      ball_y_q;
    logic        dx_q;          // 1 = moving right
    logic        dy_q;          // 1 = moving down
    score_t      score_l_q;
    score_t      score_r_q;
    logic        point_pulse_q;
    logic        game_over_q;

    coord_t      paddle_l_y;
    coord_t      paddle_r_y;
    logic        paddle_en;
    logic        r_up;
    logic        r_dn;

    coord_t      ball_x_d;
    coord_t      ball_y_d;
    logic        dx_d;
    logic        dy_d;
    logic        miss_r;
    logic        miss_l;
    logic        win;

    sum_t        bx;
    sum_t        by;
    sum_t        pl;
    sum_t        pr;
    logic        ovl_l;
    logic        ovl_r;

    assign bx = widen(ball_x_q);
    assign by = widen(ball_y_q);
    assign pl = widen(paddle_l_y);
    assign pr = widen(paddle_r_y);

    // Paddles are frozen in GAME_OVER; a tick dropped there never moves them.
    assign paddle_en = frame_tick_i && (state_q != GAME_OVER);

`ifdef PONG_AUTOPLAY_EN
    sum_t ball_c;
    sum_t pad_c;
    logic unused_btn_r;

    assign unused_btn_r = btn_r_up_i ^ btn_r_dn_i;
    assign ball_c       = by + K_BALL_HALF;
    assign pad_c        = pr + K_PADDLE_HALF;

    // Chase the ball centre with a small dead band to avoid dithering.
    always_comb begin
        r_up = (ball_c + K_AUTO_DEAD) < pad_c;
        r_dn = ball_c > (pad_c + K_AUTO_DEAD);
    end
`else
    assign r_up = btn_r_up_i;
    assign r_dn = btn_r_dn_i;
`endif

    pong_paddle_ctrl u_paddle_l (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (paddle_en),
        .up_i    (btn_l_up_i),
        .dn_i    (btn_l_dn_i),
        .y_o     (paddle_l_y)
    );

    pong_paddle_ctrl u_paddle_r (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (paddle_en),
        .up_i    (r_up),
        .dn_i    (r_dn),
        .y_o     (paddle_r_y)
    );

    // One PLAY step: wall bounce on y, then paddle hit / miss / step on x.
    always_comb begin
        ball_y_d = ball_y_q;
        dy_d     = dy_q;
        if (dy_q) begin
            if (by + K_BALL_SIZE + K_BALL_SPEED >= K_SCREEN_H) begin
                ball_y_d = C_BALL_Y_MAX;
                dy_d     = 1'b0;
            end else begin
                ball_y_d = ball_y_q + C_BALL_SPEED;
            end
        end else begin
            if (by < K_BALL_SPEED) begin
                ball_y_d = '0;
                dy_d     = 1'b1;
            end else begin
                ball_y_d = ball_y_q - C_BALL_SPEED;
            end
        end

        ovl_r = (by + K_BALL_SIZE > pr) && (by < pr + K_PADDLE_H);
        ovl_l = (by + K_BALL_SIZE > pl) && (by < pl + K_PADDLE_H);

        ball_x_d = ball_x_q;
        dx_d     = dx_q;
        miss_r   = 1'b0;
        miss_l   = 1'b0;
        if (dx_q && (bx + K_BALL_SIZE + K_BALL_SPEED >= K_PADDLER_X) &&
            (bx + K_BALL_SIZE <= K_PADDLER_X) && ovl_r) begin
            ball_x_d = C_RHIT_X;
            dx_d     = 1'b0;
        end else if (!dx_q && (bx <= K_LHIT_X + K_BALL_SPEED) &&
                     (bx >= K_LHIT_X) && ovl_l) begin
            ball_x_d = C_LHIT_X;
            dx_d     = 1'b1;
        end else if (dx_q && (bx + K_BALL_SIZE + K_BALL_SPEED >= K_SCREEN_W)) begin
            miss_r = 1'b1;
        end else if (!dx_q && (bx < K_BALL_SPEED)) begin
            miss_l = 1'b1;
        end else begin
            ball_x_d = dx_q ? ball_x_q + C_BALL_SPEED : ball_x_q - C_BALL_SPEED;
        end

        win = miss_r ? ((score_l_q + C_SCORE_ONE) == C_WIN)
                     : ((score_r_q + C_SCORE_ONE) == C_WIN);
    end

    // Game sequencer with registered ball, scores and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= SERVE;
            serve_cnt_q   <= '0;
            ball_x_q      <= C_BALL_X0;
            ball_y_q      <= C_BALL_Y0;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            score_l_q     <= '0;
            score_r_q     <= '0;
            point_pulse_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            point_pulse_q <= 1'b0;
            case (state_q)
                SERVE: begin
                    if (frame_tick_i) begin
                        if (serve_cnt_q == C_SERVE_LAST) begin
                            serve_cnt_q <= '0;
                            state_q     <= PLAY;
                        end else begin
                            serve_cnt_q <= serve_cnt_q + C_SERVE_ONE;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick_i) begin
                        if (miss_r || miss_l) begin
                            ball_x_q      <= C_BALL_X0;
                            ball_y_q      <= C_BALL_Y0;
                            dx_q          <= miss_r;
                            point_pulse_q <= 1'b1;
                            if (miss_r) begin
                                score_l_q <= score_l_q + C_SCORE_ONE;
                            end else begin
                                score_r_q <= score_r_q + C_SCORE_ONE;
                            end
                            if (win) begin
                                state_q     <= GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                state_q <= SERVE;
                            end
                        end else begin
                            ball_x_q <= ball_x_d;
                            ball_y_q <= ball_y_d;
                            dx_q     <= dx_d;
                            dy_q     <= dy_d;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start_i) begin
                        state_q     <= SERVE;
                        serve_cnt_q <= '0;
                        ball_x_q    <= C_BALL_X0;
                        ball_y_q    <= C_BALL_Y0;
                        dx_q        <= 1'b1;
                        dy_q        <= 1'b1;
                        score_l_q   <= '0;
                        score_r_q   <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SERVE;
                end
            endcase
        end
    end

    assign ball_x_o      = ball_x_q;
    assign ball_y_o      = ball_y_q;
    assign paddleL_y_o   = paddle_l_y;
    assign paddleR_y_o   = paddle_r_y;
    assign score_l_o     = score_l_q;
    assign score_r_o     = score_r_q;
    assign point_pulse_o = point_pulse_q;
    assign game_over_o   = game_over_q;

endmodule

// File: tb/tb_pong_game_state.sv
// Bench for pong_game_state (default build, PONG_AUTOPLAY_EN undefined).
module tb_pong_game_state;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, start;
    logic       bl_up, bl_dn, br_up, br_dn;
    logic [9:0] ball_x, ball_y, pl_y, pr_y;
    logic [3:0] score_l, score_r;
    logic       point_pulse, game_over;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pong_game_state dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .frame_tick_i  (frame_tick),
        .btn_l_up_i    (bl_up),
        .btn_l_dn_i    (bl_dn),
        .btn_r_up_i    (br_up),
        .btn_r_dn_i    (br_dn),
        .start_i       (start),
        .ball_x_o      (ball_x),
        .ball_y_o      (ball_y),
        .paddleL_y_o   (pl_y),
        .paddleR_y_o   (pr_y),
        .score_l_o     (score_l),
        .score_r_o     (score_r),
        .point_pulse_o (point_pulse),
        .game_over_o   (game_over)
    );

    // Reference game, kept in plain integers straight from the game rules.
    int m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_frames;
    bit m_right, m_down, m_serving, m_over, m_pulse;

    typedef struct {
        bit lu, ld, ru, rd;
        int exp_l, exp_r;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int pad_step(input int y, input bit up, input bit dn);
        if (up && !dn) return (y < 4) ? 0 : y - 4;
        if (dn && !up) return (y + 4 > 420) ? 420 : y + 4;
        return y;
    endfunction

    task automatic model_reset();
        m_bx = 315; m_by = 235; m_pl = 210; m_pr = 210;
        m_sl = 0; m_sr = 0; m_frames = 0;
        m_right = 1; m_down = 1; m_serving = 1; m_over = 0; m_pulse = 0;
    endtask

    task automatic model_restart();
        m_bx = 315; m_by = 235; m_sl = 0; m_sr = 0; m_frames = 0;
        m_right = 1; m_down = 1; m_serving = 1; m_over = 0; m_pulse = 0;
    endtask

    task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd);
        int npl, npr, nx, ny;
        bit nright, ndown;
        m_pulse = 0;
        if (m_over) return;
        npl = pad_step(m_pl, lu, ld);
        npr = pad_step(m_pr, ru, rd);
        if (m_serving) begin
            m_frames++;
            if (m_frames == 60) begin
                m_frames  = 0;
                m_serving = 0;
            end
        end else begin
            ny = m_by; ndown = m_down;
            if (m_down) begin
                if (m_by + 12 >= 480) begin ny = 470; ndown = 0; end
                else ny = m_by + 2;
            end else begin
                if (m_by < 2) begin ny = 0; ndown = 1; end
                else ny = m_by - 2;
            end
            nx = m_bx; nright = m_right;
            if (m_right && m_bx + 12 >= 630 && m_bx + 10 <= 630 &&
                m_by + 10 > m_pr && m_by < m_pr + 60) begin
                nx = 620; nright = 0;
            end else if (!m_right && m_bx - 2 <= 13 && m_bx >= 13 &&
                         m_by + 10 > m_pl && m_by < m_pl + 60) begin
                nx = 13; nright = 1;
            end else if ((m_right && m_bx + 12 >= 640) || (!m_right && m_bx < 2)) begin
                if (m_right) m_sl++; else m_sr++;
                nx = 315; ny = 235; ndown = m_down; nright = m_right;
                m_pulse = 1;
                if (m_sl == 9 || m_sr == 9) m_over = 1;
                else m_serving = 1;
            end else begin
                nx = m_right ? m_bx + 2 : m_bx - 2;
            end
            m_bx = nx; m_by = ny; m_right = nright; m_down = ndown;
        end
        m_pl = npl; m_pr = npr;
    endtask

    task automatic compare_all();
        check("ball_x", ball_x, m_bx);
        check("ball_y", ball_y, m_by);
        check("paddleL_y", pl_y, m_pl);
        check("paddleR_y", pr_y, m_pr);
        check("score_l", score_l, m_sl);
        check("score_r", score_r, m_sr);
        check("point_pulse", point_pulse, m_pulse);
        check("game_over", game_over, m_over);
    endtask

    task automatic do_reset();
        rst_n = 0; frame_tick = 0; start = 0;
        bl_up = 0; bl_dn = 0; br_up = 0; br_dn = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        compare_all();
    endtask

    // One frame tick with the given buttons, then gap-1 idle cycles.
    task automatic tick(input bit lu, input bit ld, input bit ru, input bit rd, input int gap);
        bl_up = lu; bl_dn = ld; br_up = ru; br_dn = rd;
        frame_tick = 1;
        @(posedge clk); #1;
        frame_tick = 0;
        model_tick(lu, ld, ru, rd);
        compare_all();
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
        check("pulse_one_cycle", point_pulse, 0);
    endtask

    task automatic start_req(input bit with_tick, input bit lu, input bit ld,
                             input bit ru, input bit rd);
        bl_up = lu; bl_dn = ld; br_up = ru; br_dn = rd;
        start = 1; frame_tick = with_tick;
        @(posedge clk); #1;
        start = 0; frame_tick = 0;
        if (m_over) model_restart();
        else if (with_tick) model_tick(lu, ld, ru, rd);
        else m_pulse = 0;
        compare_all();
        @(posedge clk); #1;
    endtask

    initial begin
        bit lu, ld, ru, rd;

        vecs[0] = '{1, 0, 0, 0, 206, 210};
        vecs[1] = '{1, 0, 0, 0, 202, 210};
        vecs[2] = '{0, 1, 0, 0, 206, 210};
        vecs[3] = '{1, 1, 0, 0, 206, 210};
        vecs[4] = '{0, 0, 0, 0, 206, 210};
        vecs[5] = '{0, 0, 0, 1, 206, 214};
        vecs[6] = '{0, 0, 1, 1, 206, 214};
        vecs[7] = '{0, 0, 1, 0, 206, 210};
        vecs[8] = '{0, 0, 1, 0, 206, 206};
        vecs[9] = '{0, 1, 0, 1, 210, 210};

        rst_n = 0; frame_tick = 0; start = 0;
        bl_up = 0; bl_dn = 0; br_up = 0; br_dn = 0;

        // Reset values
        do_reset();
        check("rst_ball_x", ball_x, 315);
        check("rst_ball_y", ball_y, 235);
        check("rst_paddleL", pl_y, 210);
        check("rst_paddleR", pr_y, 210);
        check("rst_game_over", game_over, 0);

        // Paddle step table during serve
        for (int i = 0; i < 10; i++) begin
            tick(vecs[i].lu, vecs[i].ld, vecs[i].ru, vecs[i].rd, 2);
            check("tbl_paddleL", pl_y, vecs[i].exp_l);
            check("tbl_paddleR", pr_y, vecs[i].exp_r);
            check("tbl_ball_held", ball_x, 315);
        end

        // Reset together with a tick mid-serve
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 2);
        rst_n = 0; frame_tick = 1;
        @(posedge clk); #1;
        rst_n = 1; frame_tick = 0;
        model_reset();
        compare_all();
        check("midrst_paddleL", pl_y, 210);
        check("midrst_paddleR", pr_y, 210);

        // Serve hold then first move
        for (int i = 1; i <= 61; i++) begin
            tick(0, 0, 0, 0, 2);
            if (i == 60) check("serve_hold_x", ball_x, 315);
            if (i == 61) begin
                check("first_move_x", ball_x, 317);
                check("first_move_y", ball_y, 237);
            end
        end

        // Left paddle clamp at the top
        do_reset();
        for (int i = 1; i <= 56; i++) begin
            tick(1, 0, 0, 0, 2);
            if (i == 52) check("clamp_52", pl_y, 2);
            if (i == 53) check("clamp_53", pl_y, 0);
            if (i == 56) check("clamp_hold", pl_y, 0);
        end
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 2);
        check("both_hold", pl_y, 0);

        // Right paddle hit: paddle parked at 398, ball arrives at (619,402)
        do_reset();
        for (int i = 1; i <= 214; i++) begin
            tick(0, 0, 0, (i <= 47), 2);
            if (i == 212) begin
                check("rhit_pre_x", ball_x, 619);
                check("rhit_pre_y", ball_y, 402);
                check("rhit_paddle", pr_y, 398);
            end
            if (i == 213) check("rhit_x", ball_x, 620);
            if (i == 214) check("rhit_back_x", ball_x, 618);
        end

        // Right paddle parked at 0: every serve is a right miss; nine ends the game
        do_reset();
        for (int p = 1; p <= 9; p++) begin
            for (int t = 1; t <= 218; t++) begin
                tick(0, 0, 1, 0, 2);
                if ((p % 2) == 0 && t == 60 + 117) check("top_pre_y", ball_y, 1);
                if ((p % 2) == 0 && t == 60 + 118) check("top_clamp_y", ball_y, 0);
                if ((p % 2) == 0 && t == 60 + 119) check("top_bounce_y", ball_y, 2);
                if (t == 60 + 157) check("miss_pre_x", ball_x, 629);
                if (t == 218) begin
                    check("miss_score_l", score_l, p);
                    check("miss_ball_x", ball_x, 315);
                    check("miss_ball_y", ball_y, 235);
                    check("miss_game_over", game_over, (p == 9));
                end
            end
            if (p < 9) begin
                tick(0, 0, 1, 0, 2);
                check("serve_after_miss", ball_x, 315);
                for (int t = 0; t < 59; t++) tick(0, 0, 1, 0, 2);
                tick(0, 0, 1, 0, 2);
                check("dx_right_after_miss", ball_x, 317);
                for (int t = 0; t < 0; t++) tick(0, 0, 0, 0, 2);
                // Re-align: the inner loop restarts at the serve, so rewind via model state.
                do_reset();
                for (int q = 0; q < p; q++) begin
                    for (int t = 1; t <= 218; t++) tick(0, 0, 1, 0, 2);
                end
            end
        end
        check("over_score_l", score_l, 9);
        check("over_flag", game_over, 1);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 2);
        check("frozen_ball_x", ball_x, 315);
        check("frozen_paddleL", pl_y, 210);
        check("frozen_score", score_l, 9);

        // Start and tick together: start wins
        start_req(1, 1, 0, 0, 0);
        check("restart_score_l", score_l, 0);
        check("restart_over", game_over, 0);
        check("restart_paddleL", pl_y, 210);
        for (int i = 1; i <= 61; i++) begin
            tick(0, 0, 0, 0, 2);
            if (i == 60) check("restart_hold_x", ball_x, 315);
            if (i == 61) begin
                check("restart_move_x", ball_x, 317);
                check("restart_move_y", ball_y, 237);
            end
        end

        // Randomized play against the reference
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            lu = $urandom_range(0, 1); ld = $urandom_range(0, 1);
            ru = $urandom_range(0, 1); rd = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7) begin
                lu = (m_by + 5 < m_pl + 30);
                ld = (m_by + 5 > m_pl + 30);
            end
            if ($urandom_range(0, 9) < 5) begin
                ru = (m_by + 5 < m_pr + 30);
                rd = (m_by + 5 > m_pr + 30);
            end
            if ($urandom_range(0, 39) == 0)
                start_req($urandom_range(0, 1), lu, ld, ru, rd);
            else
                tick(lu, ld, ru, rd, $urandom_range(2, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_state.md
# pong_game_state

Frame-rate game engine for Pong, upstream of the pixel renderer. It owns the ball position and direction, both paddle positions, the scores and the serve/play/game-over sequencing. It advances once per `frame_tick` and presents registered coordinates (`ball_x`, `ball_y`, `paddleL_y`, `paddleR_y`) that hold steady for the whole active frame the renderer draws.

## Interface
- `SCREEN_W`, 640: visible width in pixels.
- `SCREEN_H`, 480: visible height in pixels.
- `BALL_SIZE`, 10: ball edge length.
- `PADDLE_W`, 10; `PADDLE_H`, 60: paddle size.
- `PADDLEL_X`, 3; `PADDLER_X`, 630: left x of each paddle.
- `BALL_SPEED`, 2: pixels per frame on each axis.
- `PADDLE_SPEED`, 4: pixels per frame.
- `SERVE_FRAMES`, 60: frames the ball waits at centre before moving.
- `WIN_SCORE`, 9: score that ends the game.

Ports:
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse at the start of vertical blank.
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn`  in  1 each  synchronized, debounced levels.
- `start`  in  1  restart request, honoured only in GAME_OVER.
- `ball_x`, `ball_y`  out  10  ball top-left corner.
- `paddleL_y`, `paddleR_y`  out  10  paddle top edge.
- `score_l`, `score_r`  out  4  scores.
- `point_pulse`  out  1  one-cycle pulse on each scored point.
- `game_over`  out  1  high while in GAME_OVER.

## Operation
- States: SERVE, PLAY, GAME_OVER. Positions, direction and scores change only on `frame_tick`.
- SERVE:
  - Ball held at centre, (SCREEN_W−BALL_SIZE)/2, (SCREEN_H−BALL_SIZE)/2 = (315,235).
  - Paddles move.
  - `serve_cnt` counts ticks. On the tick where it equals SERVE_FRAMES−1, the block clears the counter and enters PLAY. The ball first moves on the following tick.
- PLAY, per tick:
  - Vertical step:
    - Moving down and `ball_y+BALL_SIZE+BALL_SPEED >= SCREEN_H`: clamp `ball_y` to SCREEN_H−BALL_SIZE and set dy to up.
    - Moving up and `ball_y < BALL_SPEED`: clamp to 0 and set dy to down.
    - Otherwise step by BALL_SPEED.
  - Horizontal step. Rules are checked in this order; the first match wins.
    1. Right paddle hit: moving right, `ball_x+BALL_SIZE+BALL_SPEED >= PADDLER_X`, `ball_x+BALL_SIZE <= PADDLER_X`, and y-overlap (`ball_y+BALL_SIZE > paddleR_y && ball_y < paddleR_y+PADDLE_H`, current values). Result: `ball_x` = PADDLER_X−BALL_SIZE, dx = left.
    2. Left paddle hit: the mirror of rule 1. Result: `ball_x` = PADDLEL_X+PADDLE_W, dx = right.
    3. Right miss: moving right and `ball_x+BALL_SIZE+BALL_SPEED >= SCREEN_W`. Result: `score_l`+1.
    4. Left miss: moving left and `ball_x < BALL_SPEED`. Result: `score_r`+1.
    5. Otherwise step by BALL_SPEED.
  - On a miss:
    - Recentre the ball in the same tick.
    - Set dx toward the player who conceded; dy is unchanged.
    - Pulse `point_pulse`.
    - Next state is GAME_OVER if the new score equals WIN_SCORE, else SERVE.
- Paddles (SERVE and PLAY):
  - Up only: y = (y < PADDLE_SPEED) ? 0 : y−PADDLE_SPEED.
  - Down only: y = min(y+PADDLE_SPEED, SCREEN_H−PADDLE_H).
  - Both buttons or neither: hold.
  - Paddles are frozen in GAME_OVER.
- GAME_OVER:
  - All positions freeze and ticks are ignored.
  - `start` clears both scores, recentres the ball, resets `serve_cnt`, sets dx = right and dy = down, and enters SERVE.
  - If `start` and `frame_tick` arrive in the same cycle, `start` wins and the tick is dropped.
- Arithmetic: all sums are 11 bits wide so nothing wraps; positions are stored in 10 bits.

## Timing
- All outputs are registered. Values update in the cycle after the `frame_tick` cycle (1-cycle latency). `point_pulse` is high for exactly that one cycle.
- Reset values:
  - Ball (315,235); both paddles (SCREEN_H−PADDLE_H)/2 = 210.
  - Scores 0; `point_pulse` 0; `game_over` 0.
  - State SERVE; `serve_cnt` 0; dx right, dy down.
- Reset asserted mid-frame or mid-serve: every register returns to its reset value on that edge, and any tick in the same cycle is ignored.
- The block tolerates `frame_tick` spacing of 2 cycles or more; a tick spacing of 1 cycle is illegal.

## Configuration
- `PONG_AUTOPLAY_EN` defined:
  - `btn_r_up`/`btn_r_dn` are ignored.
  - Each tick, the right paddle moves PADDLE_SPEED (clamped) toward the ball: up if ball centre < paddle centre−2, down if > paddle centre+2, else hold.
- Undefined: the right paddle is driven by its buttons exactly like the left.

## Structure
- `pong_pkg`: screen and geometry constants shared with the renderer, the `game_state_t` enum (SERVE/PLAY/GAME_OVER) and the 10-bit coordinate typedef.
- Sub-module `pong_paddle_ctrl`: one paddle's clamped up/down step, taking an enable and the up/down requests. It is instantiated twice; the autoplay logic drives the right instance's requests.

## Test plan
- **Reset and serve:** reset, then 60 ticks → ball stays (315,235), paddles 210, scores 0. 61st tick → ball (317,237).
- **Paddle clamp:** hold `btn_l_up` → `paddleL_y` 206, 202, …, 2, then 0 on the 53rd tick, then stays 0. `btn_l_up`+`btn_l_dn` together → holds.
- **Top wall bounce:** PLAY, ball_y=1 moving up → next tick ball_y=0 with dy down, next tick ball_y=2.
- **Right paddle hit:** `paddleR_y`=210, ball (619,235) moving right → next tick `ball_x`=620 with dx left, following tick 618.
- **Right miss:** `paddleR_y`=0, ball (628,400) moving right → `score_l`=1, `point_pulse` high for 1 cycle, ball (315,235), SERVE, dx right.
- **Game over:** `score_l`=8, right miss → `score_l`=9, `game_over`=1, later ticks change nothing. Then `start` and `frame_tick` in the same cycle → scores 0, SERVE, ball (315,235).
